// File: rtl/pif_ram_port_arbiter_if.sv
// PIF RAM byte-port bundle: two requesters (m0 = CPU window, m1 = joybus DMA) plus the RAM side.
// slave = arbiter view, master = requester/RAM-model view.
interface pif_ram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ready;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ready;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_addr, mem_we, mem_oe, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_addr, mem_we, mem_oe, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pif_ram_port_arbiter.sv
// Per-access arbiter for the PIF RAM CPU byte port: m0 priority, m1 starvation guard, lock for RMW.
// Accept in N -> RAM strobe in N+1 -> rvalid in N+1+RD_LATENCY; a requester waits (ready low) while it loses.
module pif_ram_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  pif_ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e                state_q,     state_d;
  logic [3:0]            starve_q,    starve_d;
  logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q,    mem_we_d;
  logic                  mem_oe_q,    mem_oe_d;
  logic                  oe_own_q,    oe_own_d;
  logic [RD_LATENCY-1:0] tag_vld_q,   tag_vld_d;
  logic [RD_LATENCY-1:0] tag_own_q,   tag_own_d;
  logic [DATA_W-1:0]     rdata0_q,    rdata0_d;
  logic [DATA_W-1:0]     rdata1_q,    rdata1_d;

  logic gnt0;
  logic gnt1;
  logic rvalid0;
  logic rvalid1;

  // Ownership and arbitration; a held lock shuts out the other requester entirely.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    case (state_q)
      LOCK0: begin
        gnt0 = bus.m0_req;
        if (!(bus.m0_req && bus.m0_lock)) state_d = IDLE;
      end
      LOCK1: begin
        gnt1 = bus.m1_req;
        if (!(bus.m1_req && bus.m1_lock)) state_d = IDLE;
      end
      default: begin
        gnt1 = bus.m1_req && (!bus.m0_req || starve_q == STARVE_MAX);
        gnt0 = bus.m0_req && !gnt1;
        if (gnt0 && bus.m0_lock)      state_d = LOCK0;
        else if (gnt1 && bus.m1_lock) state_d = LOCK1;
      end
    endcase

    starve_d = starve_q;
    if (gnt1) begin
      starve_d = '0;
    end else if (bus.m1_req && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    mem_we_d    = (gnt0 && bus.m0_we)  || (gnt1 && bus.m1_we);
    mem_oe_d    = (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);
    oe_own_d    = gnt1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt1) begin
      mem_addr_d  = bus.m1_addr;
      mem_wdata_d = bus.m1_wdata;
    end else if (gnt0) begin
      mem_addr_d  = bus.m0_addr;
      mem_wdata_d = bus.m0_wdata;
    end
  end

  // Owner tag rides alongside the RAM read latency so returns go back in issue order.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = mem_oe_q;
    tag_own_d[0] = oe_own_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_comb begin
    rvalid0  = tag_vld_q[RD_LATENCY-1] && !tag_own_q[RD_LATENCY-1];
    rvalid1  = tag_vld_q[RD_LATENCY-1] &&  tag_own_q[RD_LATENCY-1];
    rdata0_d = rvalid0 ? bus.mem_rdata : rdata0_q;
    rdata1_d = rvalid1 ? bus.mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      oe_own_q    <= 1'b0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      oe_own_q    <= oe_own_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.m0_ready  = gnt0;
  assign bus.m1_ready  = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rdata0_d;
  assign bus.m1_rdata  = rdata1_d;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
endmodule

// File: tb/tb_pif_ram_port_arbiter.sv
// Directed checks on a RD_LATENCY=1 arbiter, then random traffic on a RD_LATENCY=3 arbiter
// against a shadow-memory / issue-order scoreboard.
module tb_pif_ram_port_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int LIMIT = 4;
  localparam int LATB  = 3;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pif_ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  pif_ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  pif_ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa)
  );
  pif_ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LATB), .STARVE_LIMIT(LIMIT)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 13 + 5);
  endfunction

  // RAM models: read data appears RD_LATENCY cycles after the cycle mem_oe is high.
  logic [7:0] ram_a [2048];
  logic [7:0] ram_b [2048];
  logic [7:0] rpa;
  logic [7:0] rpb [LATB];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) begin
        ram_a[i] <= init_val(i);
        ram_b[i] <= init_val(i);
      end
    end else begin
      if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
      if (ifa.mem_oe) rpa <= ram_a[ifa.mem_addr];
      if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
      if (ifb.mem_oe) rpb[0] <= ram_b[ifb.mem_addr];
      for (int i = 1; i < LATB; i++) rpb[i] <= rpb[i-1];
    end
  end
  assign ifa.mem_rdata = rpa;
  assign ifb.mem_rdata = rpb[LATB-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic lk,
                     input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (m == 0) begin
      ifa.m0_req = req; ifa.m0_we = we; ifa.m0_lock = lk; ifa.m0_addr = ad; ifa.m0_wdata = wd;
    end else begin
      ifa.m1_req = req; ifa.m1_we = we; ifa.m1_lock = lk; ifa.m1_addr = ad; ifa.m1_wdata = wd;
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         own;
    logic [7:0] data;
    int         cyc;
  } rd_t;

  rd_t        q[$];
  logic [7:0] shadow [2048];
  logic       rq  [2];
  logic       rwe [2];
  logic       rlk [2];
  logic [AW-1:0] rad [2];
  logic [DW-1:0] rwd [2];
  logic       e   [2];
  int         lock_own;
  int         starve;
  int         reads_done;

  initial begin
    rst = 1'b1;
    ram_init = 1'b1;
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
    ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_lock = 0; ifb.m0_addr = '0; ifb.m0_wdata = '0;
    ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_lock = 0; ifb.m1_addr = '0; ifb.m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 ram_init = 1'b0;

    @(negedge clk);
    check("rst_mem_oe",    ifa.mem_oe,    0);
    check("rst_mem_we",    ifa.mem_we,    0);
    check("rst_mem_addr",  ifa.mem_addr,  0);
    check("rst_mem_wdata", ifa.mem_wdata, 0);
    check("rst_m0_rvalid", ifa.m0_rvalid, 0);
    check("rst_m1_rvalid", ifa.m1_rvalid, 0);
    check("rst_m0_rdata",  ifa.m0_rdata,  0);
    check("rst_m1_rdata",  ifa.m1_rdata,  0);
    check("rst_m0_ready",  ifa.m0_ready,  0);
    nxt;
    rst = 1'b0;

    // Single m0 read of 0x010.
    drv(0, 1, 0, 0, 11'h010, 0);
    @(negedge clk);
    check("t1_m0_ready", ifa.m0_ready, 1);
    check("t1_m1_ready", ifa.m1_ready, 0);
    nxt; drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_mem_oe",    ifa.mem_oe,    1);
    check("t1_mem_we",    ifa.mem_we,    0);
    check("t1_mem_addr",  ifa.mem_addr,  11'h010);
    check("t1_early_rv",  ifa.m0_rvalid, 0);
    nxt;
    @(negedge clk);
    check("t1_m0_rvalid", ifa.m0_rvalid, 1);
    check("t1_m0_rdata",  ifa.m0_rdata,  init_val(16));
    check("t1_m1_rvalid", ifa.m1_rvalid, 0);
    nxt;
    @(negedge clk);
    check("t1_rv_pulse",  ifa.m0_rvalid, 0);
    check("t1_rdata_hold", ifa.m0_rdata, init_val(16));

    // Continuous contention: four m0 grants then one forced m1 grant.
    for (int i = 0; i < 9; i++) begin
      nxt;
      drv(0, 1, 0, 0, 11'h100, 0);
      drv(1, 1, 0, 0, 11'h200, 0);
      @(negedge clk);
      check($sformatf("t2_grant%0d", i), {ifa.m1_ready, ifa.m0_ready}, (i % 5 == 4) ? 2 : 1);
    end

    // Starve count is at limit: m1 locked write then unlocked read, m0 shut out.
    nxt;
    drv(1, 1, 1, 1, 11'h7A0, 8'h5C);
    drv(0, 1, 0, 0, 11'h020, 0);
    @(negedge clk);
    check("t3_wr_m1_ready", ifa.m1_ready, 1);
    check("t3_wr_m0_ready", ifa.m0_ready, 0);
    nxt;
    drv(1, 1, 0, 0, 11'h7A0, 0);
    @(negedge clk);
    check("t3_rd_m1_ready", ifa.m1_ready, 1);
    check("t3_rd_m0_ready", ifa.m0_ready, 0);
    check("t3_mem_we",      ifa.mem_we,    1);
    check("t3_mem_addr",    ifa.mem_addr,  11'h7A0);
    check("t3_mem_wdata",   ifa.mem_wdata, 8'h5C);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_m0_after",    ifa.m0_ready, 1);
    check("t3_m1_after",    ifa.m1_ready, 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_m1_rvalid",   ifa.m1_rvalid, 1);
    check("t3_m1_rdata",    ifa.m1_rdata,  8'h5C);
    check("t3_m0_no_rv",    ifa.m0_rvalid, 0);
    nxt;
    @(negedge clk);
    check("t3_m0_rvalid",   ifa.m0_rvalid, 1);
    check("t3_m0_rdata",    ifa.m0_rdata,  init_val(32'h20));

    // Back-to-back reads from different owners.
    nxt;
    drv(0, 1, 0, 0, 11'h001, 0);
    @(negedge clk);
    check("t4_m0_ready", ifa.m0_ready, 1);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 11'h002, 0);
    @(negedge clk);
    check("t4_m1_ready", ifa.m1_ready, 1);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_m0_rvalid", ifa.m0_rvalid, 1);
    check("t4_m0_rdata",  ifa.m0_rdata,  init_val(1));
    check("t4_m1_idle",   ifa.m1_rvalid, 0);
    nxt;
    @(negedge clk);
    check("t4_m1_rvalid", ifa.m1_rvalid, 1);
    check("t4_m1_rdata",  ifa.m1_rdata,  init_val(2));
    check("t4_m0_idle",   ifa.m0_rvalid, 0);

    // Reset while a read is in flight.
    nxt;
    drv(0, 1, 0, 0, 11'h030, 0);
    @(negedge clk);
    check("t5_m0_ready", ifa.m0_ready, 1);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_mem_oe_pre", ifa.mem_oe, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_mem_oe_rst",   ifa.mem_oe,    0);
    check("t5_mem_addr_rst", ifa.mem_addr,  0);
    check("t5_rvalid_rst",   ifa.m0_rvalid, 0);
    check("t5_rdata_rst",    ifa.m0_rdata,  0);
    nxt;
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_rv_0", ifa.m0_rvalid, 0);
    nxt;
    @(negedge clk);
    check("t5_no_rv_1", ifa.m0_rvalid, 0);

    // Random traffic on the RD_LATENCY=3 instance.
    for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
    lock_own   = -1;
    starve     = 0;
    reads_done = 0;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 0; rwe[r] = 0; rlk[r] = 0; rad[r] = '0; rwd[r] = '0;
    end
    for (int it = 0; it < 3010; it++) begin
      nxt;
      for (int r = 0; r < 2; r++) begin
        if (it < 3000 && !rq[r] && $urandom_range(0, 3) != 0) begin
          rq[r]  = 1'b1;
          rwe[r] = 1'($urandom_range(0, 1));
          rlk[r] = ($urandom_range(0, 3) == 0);
          rad[r] = AW'($urandom_range(0, 15));
          rwd[r] = DW'($urandom);
        end
      end
      ifb.m0_req = rq[0]; ifb.m0_we = rwe[0]; ifb.m0_lock = rlk[0]; ifb.m0_addr = rad[0]; ifb.m0_wdata = rwd[0];
      ifb.m1_req = rq[1]; ifb.m1_we = rwe[1]; ifb.m1_lock = rlk[1]; ifb.m1_addr = rad[1]; ifb.m1_wdata = rwd[1];
      @(negedge clk);

      e[0] = 0; e[1] = 0;
      if (lock_own == 0)      e[0] = rq[0];
      else if (lock_own == 1) e[1] = rq[1];
      else if (rq[0] && rq[1]) begin
        if (starve == LIMIT) e[1] = 1; else e[0] = 1;
      end else begin
        e[0] = rq[0]; e[1] = rq[1];
      end
      check("rnd_ready0", ifb.m0_ready, e[0]);
      check("rnd_ready1", ifb.m1_ready, e[1]);

      check("rnd_rvalid0", ifb.m0_rvalid, q.size() > 0 && q[0].cyc == it && q[0].own == 0);
      check("rnd_rvalid1", ifb.m1_rvalid, q.size() > 0 && q[0].cyc == it && q[0].own == 1);
      if (q.size() > 0 && q[0].cyc == it) begin
        if (q[0].own == 0) check("rnd_rdata0", ifb.m0_rdata, q[0].data);
        else               check("rnd_rdata1", ifb.m1_rdata, q[0].data);
        reads_done++;
      end
      while (q.size() > 0 && q[0].cyc <= it) void'(q.pop_front());

      if (lock_own < 0) begin
        if (e[0] && rlk[0])      lock_own = 0;
        else if (e[1] && rlk[1]) lock_own = 1;
      end else if (!rq[lock_own] || (e[lock_own] && !rlk[lock_own])) begin
        lock_own = -1;
      end
      if (e[1]) starve = 0;
      else if (rq[1] && starve < LIMIT) starve++;

      for (int r = 0; r < 2; r++) begin
        if (e[r]) begin
          if (rwe[r]) shadow[rad[r]] = rwd[r];
          else q.push_back('{r, shadow[rad[r]], it + 1 + LATB});
          rq[r] = 1'b0;
        end
      end
    end
    check("rnd_drained",  q.size(), 0);
    check("rnd_activity", reads_done > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
